// File: rtl/tof_pkg.sv
// Shared types and the 2-of-5 decode table for the word deframer and its checker.
// Table index is the BCD digit; entry is its bit4..bit0 code (weights 7,4,2,1,0).
package tof_pkg;

  typedef logic [4:0] tof_code_t;
  typedef logic [3:0] tof_digit_t;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam tof_digit_t TOF_BAD_DIGIT = 4'hF;

  localparam tof_code_t TOF_CODE_TABLE [10] = '{
    5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
    5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100
  };

endpackage

// File: rtl/tof_word_deframer_if.sv
// Serial-in / word-out port bundle of the deframer; slave = deframer, master = line side + consumer.
// err_cnt and its width parameter exist only when TOF_ERR_CNT_EN is defined.
interface tof_word_deframer_if
`ifdef TOF_ERR_CNT_EN
  #(parameter int ERR_CNT_W = 8)
`endif
  ;
  import tof_pkg::*;

  logic       sdata;
  logic       svalid;
  logic       sync;
  tof_code_t  code;
  tof_digit_t digit;
  logic       det;
  logic       ovalid;
  logic       oready;
  logic       overflow;
  logic       frame_err;
`ifdef TOF_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  modport slave (
    input  sdata, svalid, sync, oready,
    output code, digit, det, ovalid, overflow, frame_err
`ifdef TOF_ERR_CNT_EN
    , output err_cnt
`endif
  );

  modport master (
    output sdata, svalid, sync, oready,
    input  code, digit, det, ovalid, overflow, frame_err
`ifdef TOF_ERR_CNT_EN
    , input err_cnt
`endif
  );

endinterface

// File: rtl/tof_word_check.sv
// Combinational 2-of-5 classifier: CODE -> {DET, DIGIT}; zero latency, no flow control.
// Any pattern outside the decode table reports DET=1 with the bad-digit marker.
module tof_word_check
  import tof_pkg::*;
(
  input  tof_code_t  code,
  output logic       det,
  output tof_digit_t digit
);

  always_comb begin
    det   = 1'b1;
    digit = TOF_BAD_DIGIT;
    for (int i = 0; i < 10; i++) begin
      if (code == TOF_CODE_TABLE[i]) begin
        det   = 1'b0;
        digit = tof_digit_t'(i);
      end
    end
  end

endmodule

// File: rtl/tof_word_deframer.sv
// Serial 2-of-5 deframer: output word registered one cycle after its 5th bit; valid/ready out.
// A word completing while the held output is not being accepted is dropped with an OVERFLOW pulse.
// Optional saturating error counter under TOF_ERR_CNT_EN.
module tof_word_deframer
  import tof_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
`ifdef TOF_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tof_word_deframer_if.slave    bus
);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  tof_code_t  shreg_q, shreg_d;
  tof_code_t  code_q, code_d;
  tof_digit_t digit_q, digit_d;
  logic       det_q, det_d;
  logic       ovalid_q, ovalid_d;
  logic       overflow_q, overflow_d;
  logic       frame_err_q, frame_err_d;

  tof_code_t  shift_in;
  logic       word_done;
  logic       word_load;
  logic       chk_det;
  tof_digit_t chk_digit;

  assign shift_in = MSB_FIRST ? {shreg_q[3:0], bus.sdata} : {bus.sdata, shreg_q[4:1]};

  // Classify the word as it enters the shift register so it is ready at the load edge.
  tof_word_check u_check (
    .code  (shift_in),
    .det   (chk_det),
    .digit (chk_digit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    code_d      = code_q;
    digit_d     = digit_q;
    det_d       = det_q;
    ovalid_d    = ovalid_q;
    overflow_d  = 1'b0;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    word_load   = 1'b0;

    case (state_q)
      HUNT: begin
        if (bus.svalid && bus.sync) begin
          state_d = SHIFT;
          cnt_d   = 3'd1;
          shreg_d = shift_in;
        end
      end
      default: begin
        if (bus.svalid) begin
          shreg_d = shift_in;
          if (bus.sync && cnt_q != 3'd0) begin
            frame_err_d = 1'b1;
            cnt_d       = 3'd1;
          end else if (cnt_q == 3'd4) begin
            cnt_d     = 3'd0;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
    endcase

    if (ovalid_q && bus.oready) begin
      ovalid_d = 1'b0;
    end

    // A slot frees up either because nothing is held or the held word leaves this cycle.
    if (word_done) begin
      if (!ovalid_q || bus.oready) begin
        word_load = 1'b1;
        code_d    = shift_in;
        digit_d   = chk_digit;
        det_d     = chk_det;
        ovalid_d  = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= 3'd0;
      shreg_q     <= '0;
      code_q      <= '0;
      digit_q     <= '0;
      det_q       <= 1'b0;
      ovalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      code_q      <= code_d;
      digit_q     <= digit_d;
      det_q       <= det_d;
      ovalid_q    <= ovalid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.code      = code_q;
  assign bus.digit     = digit_q;
  assign bus.det       = det_q;
  assign bus.ovalid    = ovalid_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

`ifdef TOF_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Only words that reach the output register count; dropped words never do.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (word_load && chk_det && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tof_word_deframer.sv
// Directed bench for tof_word_deframer (MSB_FIRST=1); error-counter checks only with TOF_ERR_CNT_EN.
module tb_tof_word_deframer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  tof_word_deframer_if bus();

  tof_word_deframer #(.MSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle with a valid bit; inputs change and outputs are sampled 1ns after the edge.
  task automatic send(input logic sd, input logic sy);
    bus.svalid = 1'b1;
    bus.sdata  = sd;
    bus.sync   = sy;
    @(posedge clk);
    #1;
    bus.svalid = 1'b0;
    bus.sync   = 1'b0;
    bus.sdata  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [4:0] w, input logic sy);
    logic [4:0] v;
    v = w;
    send(v[4], sy);
    for (int i = 3; i >= 0; i--) send(v[i], 1'b0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.sdata  = 1'b0;
    bus.svalid = 1'b0;
    bus.sync   = 1'b0;
    bus.oready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_code",      {3'b0, bus.code}, 8'h00);
    check("rst_digit",     {4'b0, bus.digit}, 8'h00);
    check("rst_det",       {7'b0, bus.det}, 8'h00);
    check("rst_ovalid",    {7'b0, bus.ovalid}, 8'h00);
    check("rst_overflow",  {7'b0, bus.overflow}, 8'h00);
    check("rst_frame_err", {7'b0, bus.frame_err}, 8'h00);
`ifdef TOF_ERR_CNT_EN
    check("rst_err_cnt",   bus.err_cnt, 8'h00);
`endif
    rst_n = 1'b1;
    idle();

    // Word 9 = 10100, first bit carries SYNC
    send_word(5'b10100, 1'b1);
    check("w9_ovalid", {7'b0, bus.ovalid}, 8'h01);
    check("w9_code",   {3'b0, bus.code}, 8'h14);
    check("w9_digit",  {4'b0, bus.digit}, 8'h09);
    check("w9_det",    {7'b0, bus.det}, 8'h00);
    idle();
    check("w9_accepted", {7'b0, bus.ovalid}, 8'h00);

    // Invalid word 11100, no SYNC needed at a word boundary
    send_word(5'b11100, 1'b0);
    check("bad_ovalid", {7'b0, bus.ovalid}, 8'h01);
    check("bad_det",    {7'b0, bus.det}, 8'h01);
    check("bad_digit",  {4'b0, bus.digit}, 8'h0F);
`ifdef TOF_ERR_CNT_EN
    check("bad_err_cnt", bus.err_cnt, 8'h01);
`endif
    idle();

    // Back-to-back words with the consumer stalled
    bus.oready = 1'b0;
    send_word(5'b00011, 1'b0);
    check("hold_digit1", {4'b0, bus.digit}, 8'h01);
    send_word(5'b01001, 1'b0);
    check("ovf_pulse",   {7'b0, bus.overflow}, 8'h01);
    check("ovf_code",    {3'b0, bus.code}, 8'h03);
    check("ovf_digit",   {4'b0, bus.digit}, 8'h01);
    idle();
    check("ovf_clear",   {7'b0, bus.overflow}, 8'h00);
    check("ovf_ovalid",  {7'b0, bus.ovalid}, 8'h01);
    check("ovf_code2",   {3'b0, bus.code}, 8'h03);
`ifdef TOF_ERR_CNT_EN
    check("ovf_err_cnt", bus.err_cnt, 8'h01);
`endif
    bus.oready = 1'b1;
    idle();
    check("ovf_drained", {7'b0, bus.ovalid}, 8'h00);

    // SYNC at a boundary is alignment; SYNC after 3 bits is a framing error
    send(1'b1, 1'b1);
    check("sync_aligned", {7'b0, bus.frame_err}, 8'h00);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    check("ferr_pulse", {7'b0, bus.frame_err}, 8'h01);
    send(1'b0, 1'b0);
    check("ferr_clear", {7'b0, bus.frame_err}, 8'h00);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check("ferr_no_word", {7'b0, bus.ovalid}, 8'h00);
    send(1'b0, 1'b0);
    check("ferr_ovalid", {7'b0, bus.ovalid}, 8'h01);
    check("ferr_code",   {3'b0, bus.code}, 8'h06);
    check("ferr_digit",  {4'b0, bus.digit}, 8'h03);
    idle();

    // SVALID gaps between every bit of 11000
    send(1'b1, 1'b0); idle();
    send(1'b1, 1'b0); idle();
    send(1'b0, 1'b0); idle();
    send(1'b0, 1'b0); idle();
    check("gap_pending", {7'b0, bus.ovalid}, 8'h00);
    send(1'b0, 1'b0);
    check("gap_ovalid", {7'b0, bus.ovalid}, 8'h01);
    check("gap_code",   {3'b0, bus.code}, 8'h18);
    check("gap_digit",  {4'b0, bus.digit}, 8'h00);
    check("gap_det",    {7'b0, bus.det}, 8'h00);
    idle();

    // Completion in the same cycle the held word is accepted
    bus.oready = 1'b0;
    send_word(5'b10001, 1'b0);
    check("sim_first", {4'b0, bus.digit}, 8'h07);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    bus.oready = 1'b1;
    send(1'b0, 1'b0);
    check("sim_overflow", {7'b0, bus.overflow}, 8'h00);
    check("sim_ovalid",   {7'b0, bus.ovalid}, 8'h01);
    check("sim_code",     {3'b0, bus.code}, 8'h12);
    check("sim_digit",    {4'b0, bus.digit}, 8'h08);
    idle();
    check("sim_drained",  {7'b0, bus.ovalid}, 8'h00);

    // Reset mid-word with a held output
    bus.oready = 1'b0;
    send_word(5'b01100, 1'b0);
    check("prerst_digit", {4'b0, bus.digit}, 8'h06);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_ovalid", {7'b0, bus.ovalid}, 8'h00);
    check("arst_code",   {3'b0, bus.code}, 8'h00);
    check("arst_digit",  {4'b0, bus.digit}, 8'h00);
    check("arst_det",    {7'b0, bus.det}, 8'h00);
`ifdef TOF_ERR_CNT_EN
    check("arst_err_cnt", bus.err_cnt, 8'h00);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.oready = 1'b1;
    send_word(5'b01010, 1'b0);
    check("hunt_ignored", {7'b0, bus.ovalid}, 8'h00);
    send_word(5'b01010, 1'b1);
    check("hunt_ovalid", {7'b0, bus.ovalid}, 8'h01);
    check("hunt_digit",  {4'b0, bus.digit}, 8'h05);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
